// File: rtl/rv_decode_queue.sv
// RV32I/RV64I decode stage: each accepted word is decoded once at enqueue and held in a DEPTH-entry queue.
// Define DECODE_ILLEGAL_EN to compute and queue a per-entry illegal-instruction flag; otherwise out_illegal is tied 0.
module rv_decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [6:0]                 out_opcode,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic                       out_rd_we,
    output logic                       out_rs1_used,
    output logic                       out_rs2_used,
    output logic [XLEN-1:0]            out_imm,
    output logic [3:0]                 out_func,
    output logic [2:0]                 out_fmt,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_INV = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rd_we;
        logic            rs1_used;
        logic            rs2_used;
        logic [XLEN-1:0] imm;
        logic [3:0]      func;
        logic [2:0]      fmt;
`ifdef DECODE_ILLEGAL_EN
        logic            illegal;
`endif
    } entry_t;

    entry_t          dec;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic            full, empty, push, pop;
    logic [2:0]      funct3;
    logic            is_shift_imm;

    assign funct3       = in_instr[14:12];
    assign is_shift_imm = (in_instr[6:0] == OP_IMM) && (funct3 == 3'b001 || funct3 == 3'b101);

    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.opcode = in_instr[6:0];
        dec.fmt    = FMT_INV;
        case (in_instr[6:0])
            OP_R: begin
                dec.fmt      = FMT_R;
                dec.rd       = in_instr[11:7];
                dec.rs1      = in_instr[19:15];
                dec.rs2      = in_instr[24:20];
                dec.rd_we    = 1'b1;
                dec.rs1_used = 1'b1;
                dec.rs2_used = 1'b1;
                dec.func     = {funct3, in_instr[30]};
            end
            OP_LOAD, OP_IMM, OP_JALR: begin
                dec.fmt      = FMT_I;
                dec.rd       = in_instr[11:7];
                dec.rs1      = in_instr[19:15];
                dec.rd_we    = 1'b1;
                dec.rs1_used = 1'b1;
                dec.imm      = XLEN'($signed(in_instr[31:20]));
                dec.func     = {funct3, is_shift_imm ? in_instr[30] : 1'b0};
            end
            OP_STORE: begin
                dec.fmt      = FMT_S;
                dec.rs1      = in_instr[19:15];
                dec.rs2      = in_instr[24:20];
                dec.rs1_used = 1'b1;
                dec.rs2_used = 1'b1;
                dec.imm      = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
                dec.func     = {funct3, 1'b0};
            end
            OP_BR: begin
                dec.fmt      = FMT_B;
                dec.rs1      = in_instr[19:15];
                dec.rs2      = in_instr[24:20];
                dec.rs1_used = 1'b1;
                dec.rs2_used = 1'b1;
                dec.imm      = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                              in_instr[11:8], 1'b0}));
                dec.func     = {funct3, 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec.fmt   = FMT_U;
                dec.rd    = in_instr[11:7];
                dec.rd_we = 1'b1;
                dec.imm   = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                dec.fmt   = FMT_J;
                dec.rd    = in_instr[11:7];
                dec.rd_we = 1'b1;
                dec.imm   = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                           in_instr[30:21], 1'b0}));
            end
            default: ;
        endcase
`ifdef DECODE_ILLEGAL_EN
        dec.illegal = (dec.fmt == FMT_INV);
        if (in_instr[6:0] == OP_R) begin
            if (in_instr[31:25] != 7'b0000000 && in_instr[31:25] != 7'b0100000)
                dec.illegal = 1'b1;
            if (in_instr[31:25] == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101)
                dec.illegal = 1'b1;
        end
        // RV64 shift-immediates carry a 6-bit shamt, so only instr[31:26] is the funct field.
        if (is_shift_imm) begin
            if (XLEN == 64) begin
                if (in_instr[31:26] != 6'b000000 && in_instr[31:26] != 6'b010000)
                    dec.illegal = 1'b1;
            end else begin
                if (in_instr[31:25] != 7'b0000000 && in_instr[31:25] != 7'b0100000)
                    dec.illegal = 1'b1;
            end
        end
`endif
    end

    assign full  = (occ_q == CW'(DEPTH));
    assign empty = (occ_q == '0);
    assign push  = in_valid && !full;
    assign pop   = out_ready && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        // Flush wins over any same-cycle push or pop; the entry being pushed is dropped.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)
                occ_d = occ_q + CW'(1);
            else if (pop && !push)
                occ_d = occ_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]     <= '0;
                mem_q[i].fmt <= FMT_INV;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            mem_q    <= mem_d;
        end
    end

    assign in_ready     = !full;
    assign out_valid    = !empty;
    assign occupancy    = occ_q;
    assign out_pc       = mem_q[rd_ptr_q].pc;
    assign out_opcode   = mem_q[rd_ptr_q].opcode;
    assign out_rd       = mem_q[rd_ptr_q].rd;
    assign out_rs1      = mem_q[rd_ptr_q].rs1;
    assign out_rs2      = mem_q[rd_ptr_q].rs2;
    assign out_rd_we    = mem_q[rd_ptr_q].rd_we;
    assign out_rs1_used = mem_q[rd_ptr_q].rs1_used;
    assign out_rs2_used = mem_q[rd_ptr_q].rs2_used;
    assign out_imm      = mem_q[rd_ptr_q].imm;
    assign out_func     = mem_q[rd_ptr_q].func;
    assign out_fmt      = mem_q[rd_ptr_q].fmt;
`ifdef DECODE_ILLEGAL_EN
    assign out_illegal  = mem_q[rd_ptr_q].illegal;
`else
    assign out_illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_rv_decode_queue.sv
// Scoreboard bench for rv_decode_queue: an independent decode model predicts each queued record.
// Expectations for out_illegal follow DECODE_ILLEGAL_EN exactly as the design is built.
module tb_rv_decode_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

`ifdef DECODE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd, out_rs1, out_rs2;
    logic            out_rd_we, out_rs1_used, out_rs2_used;
    logic [XLEN-1:0] out_imm;
    logic [3:0]      out_func;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [CW-1:0]   occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd, rs1, rs2;
        logic            rd_we, rs1_used, rs2_used;
        logic [XLEN-1:0] imm;
        logic [3:0]      func;
        logic [2:0]      fmt;
        logic            illegal;
    } exp_t;

    exp_t sb[$];

    rv_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd_we(out_rd_we), .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
        .out_imm(out_imm), .out_func(out_func), .out_fmt(out_fmt),
        .out_illegal(out_illegal), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference decode built from explicit bit placement and 64-bit arithmetic sign extension.
    function automatic exp_t model(input logic [31:0] w, input logic [XLEN-1:0] pc);
        exp_t e;
        logic [63:0] v;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        e.pc = pc; e.opcode = w[6:0];
        e.rd = 0; e.rs1 = 0; e.rs2 = 0;
        e.rd_we = 0; e.rs1_used = 0; e.rs2_used = 0;
        e.imm = 0; e.func = 0; e.fmt = 3'd7; e.illegal = ILL_EN;
        v = 64'd0;
        case (w[6:0])
            7'h33: begin
                e.fmt = 3'd0; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
                e.rd_we = 1; e.rs1_used = 1; e.rs2_used = 1;
                e.func = {f3, w[30]};
                e.illegal = ILL_EN && ((f7 != 7'h00 && f7 != 7'h20) ||
                                       (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5));
            end
            7'h03, 7'h13, 7'h67: begin
                e.fmt = 3'd1; e.rd = w[11:7]; e.rs1 = w[19:15];
                e.rd_we = 1; e.rs1_used = 1;
                v = {{52{w[31]}}, w[31:20]};
                e.illegal = 1'b0;
                if (w[6:0] == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    e.func = {f3, w[30]};
                    if (XLEN == 64)
                        e.illegal = ILL_EN && (w[31:26] != 6'h00 && w[31:26] != 6'h10);
                    else
                        e.illegal = ILL_EN && (f7 != 7'h00 && f7 != 7'h20);
                end else begin
                    e.func = {f3, 1'b0};
                end
            end
            7'h23: begin
                e.fmt = 3'd2; e.rs1 = w[19:15]; e.rs2 = w[24:20];
                e.rs1_used = 1; e.rs2_used = 1; e.func = {f3, 1'b0}; e.illegal = 0;
                v = {{52{w[31]}}, w[31:25], w[11:7]};
            end
            7'h63: begin
                e.fmt = 3'd3; e.rs1 = w[19:15]; e.rs2 = w[24:20];
                e.rs1_used = 1; e.rs2_used = 1; e.func = {f3, 1'b0}; e.illegal = 0;
                v = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4; e.rd = w[11:7]; e.rd_we = 1; e.illegal = 0;
                v = {{32{w[31]}}, w[31:12], 12'h000};
            end
            7'h6F: begin
                e.fmt = 3'd5; e.rd = w[11:7]; e.rd_we = 1; e.illegal = 0;
                v = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            default: ;
        endcase
        e.imm = v[XLEN-1:0];
        return e;
    endfunction

    // Scoreboard: at each falling edge, predict what the coming rising edge will do.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("pc",       64'(out_pc),       64'(e.pc));
                    checkOutput("opcode",   64'(out_opcode),   64'(e.opcode));
                    checkOutput("rd",       64'(out_rd),       64'(e.rd));
                    checkOutput("rs1",      64'(out_rs1),      64'(e.rs1));
                    checkOutput("rs2",      64'(out_rs2),      64'(e.rs2));
                    checkOutput("rd_we",    64'(out_rd_we),    64'(e.rd_we));
                    checkOutput("rs1_used", 64'(out_rs1_used), 64'(e.rs1_used));
                    checkOutput("rs2_used", 64'(out_rs2_used), 64'(e.rs2_used));
                    checkOutput("imm",      64'(out_imm),      64'(e.imm));
                    checkOutput("func",     64'(out_func),     64'(e.func));
                    checkOutput("fmt",      64'(out_fmt),      64'(e.fmt));
                    checkOutput("illegal",  64'(out_illegal),  64'(e.illegal));
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(in_instr, in_pc));
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] w, input logic [XLEN-1:0] pc,
                                 input logic rdy, input logic fl);
        in_valid  = v;
        in_instr  = w;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randWord();
        logic [6:0]  ops [11];
        logic [31:0] r;
        ops = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0B};
        r = $urandom();
        return {r[31:7], ops[$urandom_range(0, 10)]};
    endfunction

    initial begin
        logic [31:0] tbl [8];
        tbl = '{32'h00A30293, 32'h40208133, 32'h0041A183, 32'hFE112E23,
                32'h800002B7, 32'h00C0006F, 32'h40515093, 32'hFFF30313};
        rst_n = 1'b0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        #12;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
        checkOutput("rst_occ",       64'(occupancy), 64'd0);
        checkOutput("rst_fmt",       64'(out_fmt),   64'd7);
        checkOutput("rst_imm",       64'(out_imm),   64'd0);
        checkOutput("rst_pc",        64'(out_pc),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1, 32'h00A30293, 32'h100, 0, 0);
        checkOutput("addi_valid", 64'(out_valid), 64'd1);
        checkOutput("addi_fmt",   64'(out_fmt),   64'd1);
        checkOutput("addi_rd",    64'(out_rd),    64'd5);
        checkOutput("addi_rs1",   64'(out_rs1),   64'd6);
        checkOutput("addi_rs2",   64'(out_rs2),   64'd0);
        checkOutput("addi_imm",   64'(out_imm),   64'h0000000A);
        checkOutput("addi_func",  64'(out_func),  64'd0);
        checkOutput("addi_rd_we", 64'(out_rd_we), 64'd1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("addi_hold",  64'(out_rd),    64'd5);
        applyStimulus(0, 0, 0, 1, 0);

        applyStimulus(1, 32'hFE000EE3, 32'h104, 0, 0);
        checkOutput("beq_fmt",  64'(out_fmt),      64'd3);
        checkOutput("beq_imm",  64'(out_imm),      64'hFFFFFFFC);
        checkOutput("beq_we",   64'(out_rd_we),    64'd0);
        checkOutput("beq_rs1u", 64'(out_rs1_used), 64'd1);
        checkOutput("beq_rs2u", 64'(out_rs2_used), 64'd1);
        applyStimulus(1, 32'hFFDFF06F, 32'h108, 1, 0);
        checkOutput("jal_fmt",  64'(out_fmt), 64'd5);
        checkOutput("jal_imm",  64'(out_imm), 64'hFFFFFFFC);
        applyStimulus(0, 0, 0, 1, 0);

        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1, tbl[i], XLEN'(32'h200 + 4 * i), 0, 0);
        checkOutput("full_in_ready", 64'(in_ready),  64'd0);
        checkOutput("full_occ",      64'(occupancy), 64'(DEPTH));
        applyStimulus(1, tbl[7], 32'h2F0, 1, 0);
        checkOutput("full_pushpop_occ", 64'(occupancy), 64'(DEPTH - 1));
        for (int i = 0; i < DEPTH - 1; i++)
            applyStimulus(0, 0, 0, 1, 0);
        checkOutput("drain_occ",   64'(occupancy), 64'd0);
        checkOutput("drain_valid", 64'(out_valid), 64'd0);

        applyStimulus(1, tbl[4], 32'h300, 0, 0);
        applyStimulus(1, tbl[5], 32'h304, 0, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, tbl[i], XLEN'(32'h308 + 4 * i), 1, 0);
            checkOutput("stream_occ", 64'(occupancy), 64'd2);
        end
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);

        for (int i = 0; i < 3; i++)
            applyStimulus(1, tbl[i], XLEN'(32'h400 + 4 * i), 0, 0);
        checkOutput("pre_flush_occ", 64'(occupancy), 64'd3);
        applyStimulus(1, tbl[6], 32'h40C, 1, 1);
        checkOutput("flush_occ",      64'(occupancy), 64'd0);
        checkOutput("flush_valid",    64'(out_valid), 64'd0);
        checkOutput("flush_in_ready", 64'(in_ready),  64'd1);
        applyStimulus(1, tbl[3], 32'h500, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);

        applyStimulus(1, 32'h0000007F, 32'h600, 0, 0);
        checkOutput("inv_fmt",     64'(out_fmt),     64'd7);
        checkOutput("inv_illegal", 64'(out_illegal), 64'(ILL_EN));
        checkOutput("inv_rd",      64'(out_rd),      64'd0);
        checkOutput("inv_imm",     64'(out_imm),     64'd0);
        checkOutput("inv_func",    64'(out_func),    64'd0);
        checkOutput("inv_rd_we",   64'(out_rd_we),   64'd0);
        applyStimulus(1, 32'h40003033, 32'h604, 1, 0);
        checkOutput("r_ill_illegal", 64'(out_illegal), 64'(ILL_EN));
        applyStimulus(0, 0, 0, 1, 0);

        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), randWord(), XLEN'($urandom()),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            checkOutput("rand_occ", 64'(occupancy), 64'(sb.size()));
        end
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(0, 0, 0, 1, 0);
        checkOutput("rand_drain_occ", 64'(occupancy), 64'd0);

        applyStimulus(1, tbl[0], 32'h700, 0, 0);
        applyStimulus(1, tbl[1], 32'h704, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_occ",   64'(occupancy), 64'd0);
        checkOutput("async_rst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
